// File: rtl/crc_sync_fifo.sv
// crc_sync_fifo: parametrised synchronous FIFO with fill count, thresholds, show-ahead and sticky error flags
module crc_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int SHOWAHEAD = 0,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [AW:0]      usedw,
    output logic             overflow,
    output logic             underflow
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wr_en, rd_en;
    always_comb begin
        empty        = cnt_q == '0;
        full         = cnt_q == (AW+1)'(DEPTH);
        almost_empty = cnt_q <= (AW+1)'(AE_LEVEL);
        almost_full  = cnt_q >= (AW+1)'(AF_LEVEL);
        wr_en        = wrreq && !full;
        rd_en        = rdreq && !empty;
        wr_ptr_d     = sclr ? '0 : wr_ptr_q + AW'(wr_en);
        rd_ptr_d     = sclr ? '0 : rd_ptr_q + AW'(rd_en);
        cnt_d        = sclr ? '0 : cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        ovf_d        = !sclr && (ovf_q || (wrreq && full));
        udf_d        = !sclr && (udf_q || (rdreq && empty));
        q_d          = sclr ? '0 : rd_en ? mem_q[rd_ptr_q] : q_q;
        usedw        = cnt_q;
        overflow     = ovf_q;
        underflow    = udf_q;
        q            = SHOWAHEAD != 0 ? (empty ? '0 : mem_q[rd_ptr_q]) : q_q;
    end
    always_ff @(posedge clock) begin
        if (wr_en && !sclr) mem_q[wr_ptr_q] <= data;
    end
    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            q_q      <= q_d;
        end
    end
endmodule

// File: tb/tb_crc_sync_fifo.sv
// tb_crc_sync_fifo: queue-model checks of normal and show-ahead FIFO instances under directed and random traffic
module tb_crc_sync_fifo;
    logic       clk = 1'b0;
    logic       sclr, wrreq, rdreq;
    logic [7:0] data;
    logic [7:0] q0, q1;
    logic       e0, f0, ae0, af0, ov0, un0;
    logic       e1, f1, ae1, af1, ov1, un1;
    logic [4:0] u0, u1;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] mq[$];
    logic [7:0] mq0 = 8'h00;
    logic       movf = 1'b0, mudf = 1'b0;

    always #5 clk = ~clk;

    crc_sync_fifo #(.SHOWAHEAD(0)) d0 (
        .clock(clk), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q0), .empty(e0), .full(f0), .almost_empty(ae0), .almost_full(af0),
        .usedw(u0), .overflow(ov0), .underflow(un0));

    crc_sync_fifo #(.SHOWAHEAD(1)) d1 (
        .clock(clk), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q1), .empty(e1), .full(f1), .almost_empty(ae1), .almost_full(af1),
        .usedw(u1), .overflow(ov1), .underflow(un1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("usedw", 32'(u0), 32'(n));
        chk("empty", 32'(e0), 32'(n == 0));
        chk("full", 32'(f0), 32'(n == 16));
        chk("almost_empty", 32'(ae0), 32'(n <= 2));
        chk("almost_full", 32'(af0), 32'(n >= 14));
        chk("overflow", 32'(ov0), 32'(movf));
        chk("underflow", 32'(un0), 32'(mudf));
        chk("q_normal", 32'(q0), 32'(mq0));
        chk("q_showahead", 32'(q1), 32'(n == 0 ? 8'h00 : mq[0]));
        chk("sa_flags", {27'd0, u1}, {27'd0, u0} ^ 32'(e1 != e0) ^ 32'(ov1 != ov0) ^ 32'(un1 != un0));
    endtask

    task automatic step(input logic s, input logic w, input logic r, input logic [7:0] d);
        int n;
        sclr = s; wrreq = w; rdreq = r; data = d;
        @(posedge clk);
        n = mq.size();
        if (s) begin
            mq.delete();
            mq0 = 8'h00;
            movf = 1'b0;
            mudf = 1'b0;
        end else begin
            if (w && n == 16) movf = 1'b1;
            if (r && n == 0) mudf = 1'b1;
            if (r && n != 0) mq0 = mq.pop_front();
            if (w && n != 16) mq.push_back(d);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
        @(negedge clk);
        step(1, 0, 0, 8'h00);
        for (int i = 1; i <= 16; i++) step(0, 1, 0, 8'(i));
        step(0, 1, 0, 8'hAA);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) step(0, 1, 1, 8'(8'h80 + i));
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h77);
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h3C);
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00);
        step(1, 1, 0, 8'hEE);
        step(0, 1, 0, 8'h5A);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 600; i++) begin
            logic rs;
            rs = $urandom_range(0, 79) == 0;
            step(rs, 1'($urandom), 1'($urandom), 8'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
